// File: rtl/vend2_ctrl_if.sv
// Vend2 bus: coin, vend, cancel and change-payout handshakes between the front end
// and the vend2 controller, plus the hopper status and credit readout.
interface vend2_ctrl_if;
  logic        money_present;
  logic [3:0]  money_amount;
  logic        vend_idle;
  logic        money_return;
  logic [3:0]  return_amount;
  logic        return_complete;
  logic        vend_request;
  logic [11:0] vend_amount;
  logic        vend_ok;
  logic        vend_reject;
  logic        vend_complete;
  logic        vend_cancel;
  logic        cancel_complete;
  logic [15:0] hopper_empty;
  logic [15:0] total;

  modport master (
    output money_present, money_amount, return_complete, vend_request, vend_amount,
           vend_complete, vend_cancel, hopper_empty,
    input  vend_idle, money_return, return_amount, vend_ok, vend_reject,
           cancel_complete, total
  );

  modport slave (
    input  money_present, money_amount, return_complete, vend_request, vend_amount,
           vend_complete, vend_cancel, hopper_empty,
    output vend_idle, money_return, return_amount, vend_ok, vend_reject,
           cancel_complete, total
  );
endinterface

// File: rtl/vend2_ctrl.sv
// Vend2 controller: accumulates coin credit, grants or rejects vends against it and
// pays change/refunds one coin at a time from the non-empty hoppers.
module vend2_ctrl #(
  parameter logic [15:0] MAX_CREDIT  = 16'd4095,
  parameter bit          AUTO_CHANGE = 1'b1,
  parameter int unsigned RET_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  vend2_ctrl_if.slave bus
);

  localparam int TmrW = $clog2(RET_TIMEOUT + 2);
  localparam logic [TmrW-1:0] TmrLast = (RET_TIMEOUT == 0) ? '0 : TmrW'(RET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CREDIT, REJECT, VEND, RET_SEL, RET_WAIT, ESC_RET, CAN_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     total_q, total_d;
  logic [3:0]      code_q, code_d;
  logic [11:0]     price_q, price_d;
  logic            cancel_q, cancel_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [3:0]      selCode;
  logic [16:0]     coinSum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      total_q  <= '0;
      code_q   <= '0;
      price_q  <= '0;
      cancel_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      code_q   <= code_d;
      price_q  <= price_d;
      cancel_q <= cancel_d;
      tmr_q    <= tmr_d;
    end
  end

  // Largest payable coin: ascending scan so the last hit wins; code 0 means none.
  always_comb begin
    selCode = '0;
    for (int k = 0; k < 16; k++) begin
      if (k != 0 && 16'(k) <= total_q && !bus.hopper_empty[k]) selCode = 4'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    code_d   = code_q;
    price_d  = price_q;
    cancel_d = cancel_q;
    tmr_d    = tmr_q;
    coinSum  = {1'b0, total_q} + 17'(bus.money_amount);
    case (state_q)
      IDLE: begin
        if (bus.vend_cancel) begin
          cancel_d = 1'b1;
          state_d  = RET_SEL;
        end else if (bus.vend_request) begin
          price_d = bus.vend_amount;
          state_d = (total_q >= {4'd0, bus.vend_amount}) ? VEND : REJECT;
        end else if (bus.money_present) begin
          if (bus.money_amount == 4'd0) begin
            state_d = CREDIT;
          end else if (coinSum <= {1'b0, MAX_CREDIT}) begin
            total_d = coinSum[15:0];
            state_d = CREDIT;
          end else begin
            code_d  = bus.money_amount;
            state_d = ESC_RET;
          end
        end
      end
      CREDIT, REJECT: state_d = IDLE;
      VEND: begin
        if (bus.vend_complete) begin
          total_d = total_q - {4'd0, price_q};
          state_d = (AUTO_CHANGE && total_d != 16'd0) ? RET_SEL : IDLE;
        end
      end
      RET_SEL: begin
        if (selCode != 4'd0) begin
          code_d  = selCode;
          tmr_d   = '0;
          state_d = RET_WAIT;
        end else begin
          state_d = cancel_q ? CAN_DONE : IDLE;
        end
      end
      RET_WAIT: begin
        if (bus.return_complete) begin
          total_d = total_q - {12'd0, code_q};
          state_d = RET_SEL;
        end else if (RET_TIMEOUT != 0 && tmr_q == TmrLast) begin
          // Dispenser stalled: give up on this coin without debiting it.
          state_d = cancel_q ? CAN_DONE : IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ESC_RET: begin
        if (bus.return_complete) state_d = IDLE;
      end
      CAN_DONE: begin
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.vend_idle       = (state_q == IDLE);
    bus.money_return    = (state_q == RET_WAIT) || (state_q == ESC_RET);
    bus.return_amount   = bus.money_return ? code_q : 4'd0;
    bus.vend_ok         = (state_q == VEND);
    bus.vend_reject     = (state_q == REJECT);
    bus.cancel_complete = (state_q == CAN_DONE);
    bus.total           = total_q;
  end

endmodule

// File: tb/tb_vend2_ctrl.sv
// Directed self-checking bench for vend2_ctrl: coins, vend grant/reject, change,
// cancel with empty hoppers, escrow return, payout timeout and mid-payout reset.
module tb_vend2_ctrl;

  localparam int KCoin   = 0;
  localparam int KVend   = 1;
  localparam int KCancel = 2;

  logic clock = 1'b0;
  logic reset;
  vend2_ctrl_if bus ();

  vend2_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int testsRun = 0;
  int testsFailed = 0;
  int cancelPulses = 0;
  int rejectCycles = 0;
  int vendOkCycles = 0;

  // Event counters sampled mid-cycle, used for "never high" / "exactly one" checks.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.cancel_complete) cancelPulses++;
      if (bus.vend_reject) rejectCycles++;
      if (bus.vend_ok) vendOkCycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Holds one request for a single edge, then releases it.
  task automatic applyStimulus(input int kind, input logic [15:0] value);
    case (kind)
      KCoin:   begin bus.money_present = 1'b1; bus.money_amount = value[3:0]; end
      KVend:   begin bus.vend_request = 1'b1; bus.vend_amount = value[11:0]; end
      default: bus.vend_cancel = 1'b1;
    endcase
    stepCycle();
    bus.money_present = 1'b0;
    bus.vend_request  = 1'b0;
    bus.vend_cancel   = 1'b0;
  endtask

  task automatic insertCoin(input logic [3:0] k, input logic [15:0] expTotal);
    applyStimulus(KCoin, {12'd0, k});
    checkOutput("coin_busy", {31'd0, bus.vend_idle}, 32'd0);
    checkOutput("coin_total", {16'd0, bus.total}, {16'd0, expTotal});
    stepCycle();
    checkOutput("coin_idle", {31'd0, bus.vend_idle}, 32'd1);
  endtask

  task automatic payCoin(input string tag, input logic [3:0] expCode, input logic [15:0] expTotalAfter);
    int n = 0;
    while (!bus.money_return && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_req"}, {31'd0, bus.money_return}, 32'd1);
    checkOutput({tag, "_code"}, {28'd0, bus.return_amount}, {28'd0, expCode});
    stepCycle();
    stepCycle();
    checkOutput({tag, "_held"}, {27'd0, bus.money_return, bus.return_amount}, {27'd1, expCode});
    bus.return_complete = 1'b1;
    stepCycle();
    bus.return_complete = 1'b0;
    checkOutput({tag, "_drop"}, {31'd0, bus.money_return}, 32'd0);
    checkOutput({tag, "_total"}, {16'd0, bus.total}, {16'd0, expTotalAfter});
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (!bus.vend_idle && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'd0, bus.vend_idle}, 32'd1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    bus.money_present   = 1'b0;
    bus.money_amount    = '0;
    bus.return_complete = 1'b0;
    bus.vend_request    = 1'b0;
    bus.vend_amount     = '0;
    bus.vend_complete   = 1'b0;
    bus.vend_cancel     = 1'b0;
    bus.hopper_empty    = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("rst_total", {16'd0, bus.total}, 32'd0);
    checkOutput("rst_outs", {27'd0, bus.money_return, bus.vend_ok, bus.vend_reject,
                bus.cancel_complete, bus.return_amount == 4'd0}, 32'd1);
    reset = 1'b0;
    stepCycle();

    // Coins 5, 10, 2 accumulate to 17.
    insertCoin(4'd5, 16'd5);
    insertCoin(4'd10, 16'd15);
    insertCoin(4'd2, 16'd17);

    // Vend 12 from 17: grant held until complete, then 5 paid back as one code-5 coin.
    base = cancelPulses;
    applyStimulus(KVend, 16'd12);
    checkOutput("vend_ok", {31'd0, bus.vend_ok}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("vend_ok_held", {31'd0, bus.vend_ok}, 32'd1);
    checkOutput("vend_total_pre", {16'd0, bus.total}, 32'd17);
    bus.vend_complete = 1'b1;
    stepCycle();
    bus.vend_complete = 1'b0;
    checkOutput("vend_ok_drop", {31'd0, bus.vend_ok}, 32'd0);
    checkOutput("vend_total", {16'd0, bus.total}, 32'd5);
    payCoin("change5", 4'd5, 16'd0);
    waitIdle("change_idle");
    checkOutput("change_nocancel", cancelPulses - base, 32'd0);

    // Price 0 is always granted, even with no credit.
    applyStimulus(KVend, 16'd0);
    checkOutput("free_ok", {31'd0, bus.vend_ok}, 32'd1);
    bus.vend_complete = 1'b1;
    stepCycle();
    bus.vend_complete = 1'b0;
    checkOutput("free_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("free_total", {16'd0, bus.total}, 32'd0);

    // Credit 3, price 4: single-cycle reject, credit untouched.
    insertCoin(4'd3, 16'd3);
    base = vendOkCycles;
    n = rejectCycles;
    applyStimulus(KVend, 16'd4);
    checkOutput("rej_pulse", {31'd0, bus.vend_reject}, 32'd1);
    stepCycle();
    checkOutput("rej_drop", {31'd0, bus.vend_reject}, 32'd0);
    checkOutput("rej_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("rej_total", {16'd0, bus.total}, 32'd3);
    checkOutput("rej_cycles", rejectCycles - n, 32'd1);
    checkOutput("rej_no_ok", vendOkCycles - base, 32'd0);

    // Credit 9 with hoppers 9 and 8 empty: cancel refunds 7 then 2.
    insertCoin(4'd6, 16'd9);
    bus.hopper_empty = 16'h0300;
    base = cancelPulses;
    applyStimulus(KCancel, 16'd0);
    payCoin("refund7", 4'd7, 16'd2);
    payCoin("refund2", 4'd2, 16'd0);
    n = 0;
    while (!bus.cancel_complete && n < 10) begin
      stepCycle();
      n++;
    end
    checkOutput("can_pulse", {31'd0, bus.cancel_complete}, 32'd1);
    stepCycle();
    checkOutput("can_drop", {31'd0, bus.cancel_complete}, 32'd0);
    checkOutput("can_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("can_count", cancelPulses - base, 32'd1);
    bus.hopper_empty = '0;

    // Build credit to 4090, then an 8 would overflow and goes back from escrow.
    for (int i = 0; i < 272; i++) begin
      applyStimulus(KCoin, 16'd15);
      stepCycle();
    end
    insertCoin(4'd10, 16'd4090);
    applyStimulus(KCoin, 16'd8);
    payCoin("escrow8", 4'd8, 16'd4090);
    waitIdle("escrow_idle");
    applyStimulus(KCoin, 16'd0);
    checkOutput("coin0_busy", {31'd0, bus.vend_idle}, 32'd0);
    checkOutput("coin0_total", {16'd0, bus.total}, 32'd4090);
    stepCycle();
    insertCoin(4'd5, 16'd4095);

    // Cancel with a stalled dispenser: 255 cycles of request, no debit, then done.
    base = cancelPulses;
    applyStimulus(KCancel, 16'd0);
    stepCycle();
    checkOutput("to_code", {28'd0, bus.return_amount}, 32'd15);
    n = 0;
    while (bus.money_return && n < 400) begin
      n++;
      stepCycle();
    end
    checkOutput("to_cycles", n, 32'd255);
    checkOutput("to_can", {31'd0, bus.cancel_complete}, 32'd1);
    checkOutput("to_total", {16'd0, bus.total}, 32'd4095);
    stepCycle();
    checkOutput("to_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("to_count", cancelPulses - base, 32'd1);

    // Reset during a payout wipes credit and returns to idle on the same edge.
    applyStimulus(KCancel, 16'd0);
    stepCycle();
    checkOutput("rw_req", {31'd0, bus.money_return}, 32'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("rw_total", {16'd0, bus.total}, 32'd0);
    checkOutput("rw_idle", {31'd0, bus.vend_idle}, 32'd1);
    checkOutput("rw_drop", {31'd0, bus.money_return}, 32'd0);
    reset = 1'b0;
    stepCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
